// File: rtl/oi_write_buffer.sv
// Output-image write buffer: queues pixel writes in a FIFO and drains them to
// the output-image memory as an Avalon-MM write master, with flush tracking.
module oi_write_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iWrreq,
    input  logic [AW-1:0]            iAddr,
    input  logic [DW-1:0]            iData,
    input  logic                     iFlush,
    output logic                     oWait_request,
    output logic [AW-1:0]            oAvm_address,
    output logic [DW-1:0]            oAvm_writedata,
    output logic [DW/8-1:0]          oAvm_byteenable,
    output logic                     oAvm_write,
    input  logic                     iAvm_waitrequest,
    output logic                     oFlush_done,
    output logic                     oOverflow,
    output logic [$clog2(DEPTH):0]   oLevel
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic {StIdle, StWrite} state_e;

    state_e            state_q, state_d;
    logic [AW+DW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              wait_q, wait_d;
    logic              ovf_q, ovf_d;
    logic              pending_q, pending_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              write_q, write_d;
    logic              empty, full, push, pop, flush_done;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign push  = iWrreq && (!full || pop);

    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);
        wait_d  = (level_d >= LW'(DEPTH - AF_MARGIN));
        ovf_d   = ovf_q | (iWrreq & ~push);
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        flush_done = 1'b0;
        pending_d  = pending_q | iFlush;
        case (state_q)
            StIdle: begin
                write_d = 1'b0;
                if (!empty) begin
                    pop              = 1'b1;
                    {addr_d, data_d} = mem_q[rd_ptr_q];
                    write_d          = 1'b1;
                    state_d          = StWrite;
                end else if (pending_q) begin
                    // A flush arriving on the done edge is absorbed into this pulse.
                    flush_done = 1'b1;
                    pending_d  = 1'b0;
                end
            end
            StWrite: begin
                if (!iAvm_waitrequest) begin
                    if (!empty) begin
                        pop              = 1'b1;
                        {addr_d, data_d} = mem_q[rd_ptr_q];
                    end else begin
                        write_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {iAddr, iData};
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            wait_q    <= 1'b0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            wait_q    <= wait_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign oWait_request   = wait_q;
    assign oAvm_address    = addr_q;
    assign oAvm_writedata  = data_q;
    assign oAvm_byteenable = '1;
    assign oAvm_write      = write_q;
    assign oFlush_done     = flush_done;
    assign oOverflow       = ovf_q;
    assign oLevel          = level_q;

endmodule
